// File: rtl/instr_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_loader_pkg
// Purpose : definitions shared by the instruction-memory loader and its byte
//           packer: the loader state encoding, the word geometry and the byte
//           used to fill out a short final word.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package instr_mem_loader_pkg;

    // Loader states. DRAIN swallows the tail of an image that is too big for
    // the store, so the host can always finish sending.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DRAIN,
        DONE
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] PAD_BYTE       = 8'h00;

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Purpose : assembles big-endian 32-bit words from a byte stream. The first
//           byte of a word lands in bits [31:24]. A word completes on its
//           4th byte, or early on a byte flagged last, in which case the
//           missing low bytes are filled with PAD_BYTE.
// Ports   :
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   clear      in   discard any partially assembled word
//   accept     in   data is being taken this cycle
//   last       in   data is the final byte of the image
//   data       in   8-bit byte
//   word_ready out  combinational: the accepted byte completes a word now
//   word       out  combinational: the completed (padded) word; only
//                   meaningful while word_ready is high
// ---------------------------------------------------------------------------
module byte_packer
    import instr_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic        last,
    input  logic [7:0]  data,
    output logic        word_ready,
    output logic [31:0] word
);

    // Only the first three bytes of a word need storage; the completing byte
    // goes straight from data into word.
    logic [23:0] sreg;
    logic [1:0]  byte_cnt;

    assign word_ready = accept && (last || byte_cnt == 2'(BYTES_PER_WORD - 1));

    // NOTE: a combinational block assigns every output first so that no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        word = '0;
        case (byte_cnt)
            2'd0:    word = {data, PAD_BYTE, PAD_BYTE, PAD_BYTE};
            2'd1:    word = {sreg[7:0], data, PAD_BYTE, PAD_BYTE};
            2'd2:    word = {sreg[15:0], data, PAD_BYTE};
            default: word = {sreg[23:0], data};
        endcase
    end

    // NOTE: registers are written with non-blocking assignments so that every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sreg     <= '0;
            byte_cnt <= '0;
        end else if (accept) begin
            if (word_ready) begin
                sreg     <= '0;
                byte_cnt <= '0;
            end else begin
                sreg     <= {sreg[15:0], data};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
// Purpose : writer side of the instruction store. Takes a program image as a
//           byte stream over a valid/ready handshake, packs it into big-endian
//           words and writes one word per cycle-long strobe at consecutive
//           word-aligned byte addresses. busy holds the core in reset while a
//           load is running.
// Ports   :
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   load_start   in   pulse; starts a load from IDLE or DONE
//   in_valid     in   host byte valid
//   in_data      in   host byte
//   in_last      in   host byte is the final byte of the image
//   in_ready     out  loader takes a byte this cycle (LOAD and DRAIN)
//   mem_we       out  store write enable, one cycle per word
//   mem_addr     out  byte address of the write (multiple of 4)
//   mem_wdata    out  word being written
//   busy         out  load in progress
//   done         out  load finished; held until next load_start or rst
//   err_overflow out  image was larger than MAX_WORDS; sticky
//   word_count   out  words written by the current or last load
// ---------------------------------------------------------------------------
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int MAX_WORDS = 16,
    parameter int CNT_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [CNT_W-1:0]  word_count
);

    localparam int PTR_W = ADDR_W - 2;

    state_t           state;
    state_t           next_state;
    logic [PTR_W-1:0] ptr;
    logic             last_q;     // completing byte of the pending word had in_last
    logic             start_ok;
    logic             accept;
    logic             word_ready;
    logic [31:0]      word;
    logic             store_full; // the word in WRITE fills the store

    assign start_ok   = load_start && (state == IDLE || state == DONE);
    // Bytes are only packed in LOAD; in DRAIN they are taken and dropped.
    assign accept     = in_valid && in_ready && (state == LOAD);
    assign store_full = (word_count == CNT_W'(MAX_WORDS - 1));

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .accept     (accept),
        .last       (in_last),
        .data       (in_data),
        .word_ready (word_ready),
        .word       (word)
    );

    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) next_state = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (word_ready) next_state = WRITE;
            end
            WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                // A last word that exactly fills the store ends cleanly.
                if (last_q)          next_state = DONE;
                else if (store_full) next_state = DRAIN;
                else                 next_state = LOAD;
            end
            DRAIN: begin
                busy = 1'b1;
                if (in_valid && in_ready && in_last) next_state = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (load_start) next_state = LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            ptr          <= '0;
            last_q       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            err_overflow <= 1'b0;
            word_count   <= '0;
        end else begin
            state    <= next_state;
            // Registered from the next state so in_ready is a clean flop output.
            in_ready <= (next_state == LOAD) || (next_state == DRAIN);

            if (start_ok) begin
                ptr          <= '0;
                word_count   <= '0;
                err_overflow <= 1'b0;
            end

            // Capture address and data on the completing edge so both are
            // stable during WRITE and hold their values afterwards.
            if (state == LOAD && word_ready) begin
                mem_addr  <= {ptr, 2'b00};
                mem_wdata <= word;
                last_q    <= in_last;
            end

            if (state == WRITE) begin
                if (word_count < CNT_W'(MAX_WORDS)) word_count <= word_count + 1'b1;
                if (ptr < PTR_W'(MAX_WORDS - 1))    ptr        <= ptr + 1'b1;
                if (!last_q && store_full)          err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory.
- Accepts a byte stream from a host (UART or testbench front end) through a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Issues one-cycle write strobes into a writable instruction store at word-aligned byte addresses, so the single-cycle core runs a program loaded at run time instead of one baked into the ROM.
- Holds the core in reset via busy while a load is in progress.

Parameters:
- ADDR_W, 6: byte-address width of the instruction store. Word index = address >> 2.
- MAX_WORDS, 16: capacity in words. Must satisfy MAX_WORDS*4 <= 2**ADDR_W.
- CNT_W, 5: width of word_count. Must hold the value MAX_WORDS.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  single-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_last  in  1  qualifies in_data as the final byte of the image.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction store write enable, one cycle per word.
- mem_addr  out  ADDR_W  byte address of the write, always a multiple of 4.
- mem_wdata  out  32  assembled instruction word.
- busy  out  1  load in progress; the core's reset is ORed with this.
- done  out  1  load finished; held until the next load_start or rst.
- err_overflow  out  1  image exceeded MAX_WORDS; sticky until the next load_start or rst.
- word_count  out  CNT_W  number of words written in the current or last load.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE. in_ready, mem_we, busy, done, err_overflow all 0. mem_addr=0, mem_wdata=0, word_count=0. Internal byte counter and shift register cleared.
- rst mid-load aborts immediately. Words already written stay in the store. No further mem_we.
- Byte acceptance: a byte is accepted when in_valid && in_ready at a clk edge. in_ready is registered and depends only on state. in_valid low stalls with no effect.
- IDLE: in_ready=0. On load_start:
  - go to LOAD;
  - clear word_count, done, err_overflow and the byte counter;
  - set the write pointer to 0.
- LOAD: in_ready=1, busy=1.
  - Each accepted byte shifts in MSB-first: sreg <= {sreg[23:0], in_data}, and byte_cnt increments (0..3).
  - Word completes on the 4th byte, or on any byte with in_last=1.
  - On a short final word, the remaining low bytes are padded with 0x00. Example: AC,25 with last -> 32'hAC250000.
  - On word completion, go to WRITE.
- WRITE (exactly 1 cycle): in_ready=0.
  - mem_we=1, mem_addr=ptr<<2, mem_wdata=assembled word. This cycle is the one immediately after the completing byte's acceptance edge (latency 1).
  - At the end of the cycle: word_count++, ptr++.
  - Next state:
    - DONE if the completing byte had in_last;
    - DRAIN if word_count has reached MAX_WORDS;
    - otherwise LOAD.
- DRAIN: in_ready=1, busy=1, err_overflow=1. Bytes are accepted and discarded, with no mem_we, until a byte with in_last is accepted; then go to DONE.
- DONE: done=1, busy=0, in_ready=0. load_start clears done and err_overflow and re-enters LOAD as from IDLE.
- load_start during LOAD, WRITE or DRAIN is ignored.
- mem_we is 0 in every state except WRITE. mem_addr and mem_wdata hold their last values outside WRITE.
- An image of exactly MAX_WORDS words whose last byte carries in_last goes to DONE with err_overflow=0.
- in_last on the 4th byte of a word produces no padding.
- word_count saturates at MAX_WORDS. The pointer never wraps past MAX_WORDS-1.

Decomposition:
- Shared package:
  - state encoding: IDLE, LOAD, WRITE, DRAIN, DONE;
  - BYTES_PER_WORD = 4;
  - pad byte = 8'h00.
- Sub-module byte_packer:
  - contains the shift register, the 2-bit byte counter and zero-pad logic;
  - outputs word_ready and word;
  - controlled by accept, last and clear.
- The FSM, pointer and status flags live in instr_mem_loader.

Test Plan:
- Load the 24-byte program 00 24 28 20 / AC 25 00 04 / 8C 26 00 04 / 10 A6 00 01 / 00 21 08 20 / 00 00 00 00, in_last on the final byte, in_valid always high:
  - 6 writes: addr 0,4,8,12,16,20 with data 00242820, AC250004, 8C260004, 10A60001, 00210820, 00000000;
  - each write lands one cycle after its 4th byte;
  - then done=1, word_count=6, err_overflow=0.
- Same image with in_valid toggled pseudo-randomly: identical write sequence; no byte duplicated or lost.
- Partial word: bytes AC,25 with last on 25 -> single write addr 0, data AC250000; done=1, word_count=1.
- Overflow: 17 words (68 bytes) with last on byte 68:
  - 16 writes, addr 0..60;
  - no write for word 17;
  - err_overflow=1, done=1, word_count=16.
- Reset and ignored start:
  - rst asserted after 2 bytes of word 3 -> all outputs return to reset values, no mem_we from then on;
  - load_start pulsed mid-LOAD -> no change to ptr or word_count.
- Reload: after DONE, load_start plus a 1-word image -> err_overflow and done cleared, write at addr 0, word_count=1.
